mem_dump_streamer: RTL and testbench

//   Reads back the CPU's 32x8 program/data memory after the CPU halts.

---
 rtl/cpu_pkg.sv | 17 +
 rtl/mem_dump_streamer.sv | 122 ++++++++++++
 tb/tb_mem_dump_streamer.sv | 313 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU constants and the memory dump FSM state type.
// Imported by the memory read-back logic that sits beside the CPU memory.
package cpu_pkg;

   localparam int unsigned CPU_DATA_W    = 8;
   localparam int unsigned CPU_ADDR_W    = 5;
   localparam int unsigned CPU_MEM_DEPTH = 32;

   typedef enum logic [2:0] {
      StIdle,
      StRead,
      StWait,
      StSend,
      StFin
   } dump_state_e;

endpackage

// File: rtl/mem_dump_streamer.sv
// Streams a window of the halted CPU's memory out over a valid/ready byte interface.
// One synchronous memory read per byte: READ issues it, WAIT captures it, SEND offers it.
module mem_dump_streamer
   import cpu_pkg::*;
#(
   parameter int unsigned DATA_W = CPU_DATA_W,
   parameter int unsigned ADDR_W = CPU_ADDR_W,
   parameter int unsigned DEPTH  = CPU_MEM_DEPTH
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              start,
   input  logic              halted,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic [ADDR_W:0]   length,
   output logic              mem_rd_en,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic [DATA_W-1:0] out_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              out_last,
   output logic              busy,
   output logic              done,
   output logic              abort
);

   localparam logic [ADDR_W:0]   LEN_MAX   = (ADDR_W + 1)'(DEPTH);
   localparam logic [ADDR_W:0]   REM_ONE   = {{ADDR_W{1'b0}}, 1'b1};
   localparam logic [ADDR_W-1:0] ADDR_ONE  = {{(ADDR_W - 1){1'b0}}, 1'b1};
   localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(DEPTH - 1);

   dump_state_e       state_q, state_d;
   logic [ADDR_W-1:0] cur_q, cur_d;
   logic [ADDR_W:0]   rem_q, rem_d;
   logic [DATA_W-1:0] data_q, data_d;
   logic              abort_q, abort_d;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q <= StIdle;
         cur_q   <= '0;
         rem_q   <= '0;
         data_q  <= '0;
         abort_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cur_q   <= cur_d;
         rem_q   <= rem_d;
         data_q  <= data_d;
         abort_q <= abort_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cur_d   = cur_q;
      rem_d   = rem_q;
      data_d  = data_q;
      abort_d = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (start && halted) begin
               if (length == '0) begin
                  state_d = StFin;
               end else begin
                  cur_d   = base_addr;
                  // Out-of-range lengths dump the whole memory once.
                  rem_d   = (length > LEN_MAX) ? LEN_MAX : length;
                  state_d = StRead;
               end
            end
         end
         StRead: begin
            if (!halted) begin
               state_d = StIdle;
               abort_d = 1'b1;
            end else begin
               state_d = StWait;
            end
         end
         StWait: begin
            if (!halted) begin
               state_d = StIdle;
               abort_d = 1'b1;
            end else begin
               data_d  = mem_rdata;
               state_d = StSend;
            end
         end
         StSend: begin
            // A falling halt wins over a same-cycle handshake; that byte is dropped.
            if (!halted) begin
               state_d = StIdle;
               abort_d = 1'b1;
            end else if (out_ready) begin
               rem_d   = rem_q - REM_ONE;
               cur_d   = (cur_q == ADDR_LAST) ? '0 : cur_q + ADDR_ONE;
               state_d = (rem_q == REM_ONE) ? StFin : StRead;
            end
         end
         StFin: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_comb begin
      mem_rd_en = (state_q == StRead);
      mem_addr  = mem_rd_en ? cur_q : '0;
      out_valid = (state_q == StSend);
      out_data  = out_valid ? data_q : '0;
      out_last  = out_valid && (rem_q == REM_ONE);
      busy      = (state_q != StIdle);
      done      = (state_q == StFin);
      abort     = abort_q;
   end

endmodule

// File: tb/tb_mem_dump_streamer.sv
// Directed bench for mem_dump_streamer with a preloaded synchronous-read memory model.
module tb_mem_dump_streamer;

   logic       clock = 1'b0;
   logic       reset = 1'b0;
   logic       start = 1'b0;
   logic       halted = 1'b1;
   logic [4:0] base_addr = '0;
   logic [5:0] length = '0;
   logic       mem_rd_en;
   logic [4:0] mem_addr;
   logic [7:0] mem_rdata;
   logic [7:0] out_data;
   logic       out_valid;
   logic       out_ready = 1'b1;
   logic       out_last;
   logic       busy;
   logic       done;
   logic       abort;

   logic [7:0] mem [32];
   int errors = 0;
   int checks = 0;
   int rd_cnt = 0;
   int done_cnt = 0;
   int abort_cnt = 0;

   logic [7:0] got_data[$];
   logic       got_last[$];
   logic [4:0] got_addr[$];
   int first_valid, done_cyc, unstable, d_rd, d_done, d_abort;
   bit timed_out;

   mem_dump_streamer dut (
      .clock    (clock),
      .reset    (reset),
      .start    (start),
      .halted   (halted),
      .base_addr(base_addr),
      .length   (length),
      .mem_rd_en(mem_rd_en),
      .mem_addr (mem_addr),
      .mem_rdata(mem_rdata),
      .out_data (out_data),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .out_last (out_last),
      .busy     (busy),
      .done     (done),
      .abort    (abort)
   );

   always #5 clock = ~clock;

   always @(posedge clock) begin
      if (mem_rd_en) mem_rdata <= mem[mem_addr];
   end

   always @(posedge clock) begin
      if (mem_rd_en) rd_cnt <= rd_cnt + 1;
      if (done) done_cnt <= done_cnt + 1;
      if (abort) abort_cnt <= abort_cnt + 1;
   end

   // Runs one dump; stall = cycles out_ready stays low per offered byte.
   task automatic run_dump(input logic [4:0] b, input logic [5:0] l, input int stall);
      int rd0, dn0, ab0, cyc, stall_cnt;
      logic [7:0] held;
      got_data.delete();
      got_last.delete();
      got_addr.delete();
      first_valid = -1;
      done_cyc = -1;
      unstable = 0;
      timed_out = 0;
      stall_cnt = 0;
      held = '0;
      @(negedge clock);
      rd0 = rd_cnt; dn0 = done_cnt; ab0 = abort_cnt;
      out_ready = (stall == 0);
      base_addr = b; length = l; start = 1'b1;
      @(negedge clock);
      start = 1'b0;
      cyc = 1;
      while (done_cyc < 0 && cyc < 600) begin
         if (mem_rd_en) got_addr.push_back(mem_addr);
         if (out_valid) begin
            if (first_valid < 0) first_valid = cyc;
            if (stall_cnt == 0) held = out_data;
            else if (out_data !== held) unstable++;
            if (stall_cnt < stall) begin
               out_ready = 1'b0;
               stall_cnt++;
            end else begin
               out_ready = 1'b1;
               got_data.push_back(out_data);
               got_last.push_back(out_last);
               stall_cnt = 0;
            end
         end else begin
            out_ready = (stall == 0);
         end
         if (done) done_cyc = cyc;
         @(negedge clock);
         cyc++;
      end
      if (done_cyc < 0) timed_out = 1;
      repeat (3) @(negedge clock);
      out_ready = 1'b1;
      d_rd = rd_cnt - rd0;
      d_done = done_cnt - dn0;
      d_abort = abort_cnt - ab0;
   endtask

   task automatic test_reset();
      reset = 1'b0;
      repeat (2) @(negedge clock);
      checks++;
      if ({busy, out_valid, mem_rd_en, done, abort, out_last, out_data, mem_addr} !== '0)
         begin errors++; $display("FAIL reset_outputs got busy=%b valid=%b rd=%b data=%h addr=%h want all 0",
                          busy, out_valid, mem_rd_en, out_data, mem_addr); end
      reset = 1'b1;
      @(negedge clock);
      checks++;
      if (busy !== 1'b0) begin errors++; $display("FAIL reset_idle busy=%b want 0", busy); end
   endtask

   task automatic test_full_dump();
      logic [31:0] last_vec;
      run_dump(5'd0, 6'd32, 0);
      checks++;
      if (timed_out) begin errors++; $display("FAIL full_timeout done never seen"); end
      checks++;
      if (got_data.size() != 32)
         begin errors++; $display("FAIL full_count got %0d bytes want 32", got_data.size()); end
      for (int i = 0; i < got_data.size() && i < 32; i++) begin
         checks++;
         if (got_data[i] !== mem[i])
            begin errors++; $display("FAIL full_byte[%0d] got %h want %h", i, got_data[i], mem[i]); end
      end
      checks++;
      if (got_data.size() == 32 && (got_data[0] !== 8'hBB || got_data[27] !== 8'hAA))
         begin errors++; $display("FAIL full_program got %h/%h want BB/AA", got_data[0], got_data[27]); end
      last_vec = '0;
      for (int i = 0; i < got_last.size() && i < 32; i++) last_vec[i] = got_last[i];
      checks++;
      if (last_vec !== 32'h8000_0000)
         begin errors++; $display("FAIL full_last got %h want 80000000", last_vec); end
      checks++;
      if (first_valid != 3) begin errors++; $display("FAIL full_latency got %0d want 3", first_valid); end
      checks++;
      if (done_cyc != 97) begin errors++; $display("FAIL full_throughput done at %0d want 97", done_cyc); end
      checks++;
      if (d_rd != 32) begin errors++; $display("FAIL full_reads got %0d want 32", d_rd); end
      checks++;
      if (d_done != 1) begin errors++; $display("FAIL full_done got %0d want 1", d_done); end
   endtask

   task automatic test_wrap();
      logic [7:0] exp_d [4];
      logic [4:0] exp_a [4];
      logic [3:0] last_vec;
      exp_d = '{8'h5E, 8'h5F, 8'hBB, 8'h41};
      exp_a = '{5'd30, 5'd31, 5'd0, 5'd1};
      run_dump(5'd30, 6'd4, 0);
      checks++;
      if (got_data.size() != 4 || got_addr.size() != 4)
         begin errors++; $display("FAIL wrap_count got %0d bytes %0d reads want 4/4",
                          got_data.size(), got_addr.size()); end
      for (int i = 0; i < 4 && i < got_data.size() && i < got_addr.size(); i++) begin
         checks++;
         if (got_data[i] !== exp_d[i] || got_addr[i] !== exp_a[i])
            begin errors++; $display("FAIL wrap[%0d] got addr=%h data=%h want addr=%h data=%h",
                             i, got_addr[i], got_data[i], exp_a[i], exp_d[i]); end
      end
      last_vec = '0;
      for (int i = 0; i < got_last.size() && i < 4; i++) last_vec[i] = got_last[i];
      checks++;
      if (last_vec !== 4'b1000) begin errors++; $display("FAIL wrap_last got %b want 1000", last_vec); end
   endtask

   task automatic test_backpressure();
      logic [7:0] exp_d [3];
      logic [2:0] last_vec;
      exp_d = '{8'h01, 8'hAA, 8'hFF};
      run_dump(5'h1A, 6'd3, 5);
      checks++;
      if (got_data.size() != 3) begin errors++; $display("FAIL bp_count got %0d want 3", got_data.size()); end
      for (int i = 0; i < 3 && i < got_data.size(); i++) begin
         checks++;
         if (got_data[i] !== exp_d[i])
            begin errors++; $display("FAIL bp_byte[%0d] got %h want %h", i, got_data[i], exp_d[i]); end
      end
      checks++;
      if (unstable != 0) begin errors++; $display("FAIL bp_stable got %0d changes want 0", unstable); end
      checks++;
      if (d_rd != 3) begin errors++; $display("FAIL bp_reads got %0d want 3", d_rd); end
      last_vec = '0;
      for (int i = 0; i < got_last.size() && i < 3; i++) last_vec[i] = got_last[i];
      checks++;
      if (last_vec !== 3'b100) begin errors++; $display("FAIL bp_last got %b want 100", last_vec); end
   endtask

   task automatic test_zero_and_not_halted();
      int rd0, dn0;
      bit saw;
      run_dump(5'd5, 6'd0, 0);
      checks++;
      if (first_valid != -1 || got_data.size() != 0)
         begin errors++; $display("FAIL zero_valid got first_valid=%0d want none", first_valid); end
      checks++;
      if (done_cyc != 1 || d_done != 1)
         begin errors++; $display("FAIL zero_done got cyc=%0d n=%0d want 1/1", done_cyc, d_done); end
      @(negedge clock);
      rd0 = rd_cnt; dn0 = done_cnt;
      halted = 1'b0; base_addr = 5'd3; length = 6'd4; start = 1'b1;
      @(negedge clock);
      start = 1'b0;
      saw = 0;
      for (int i = 0; i < 8; i++) begin
         if (busy || out_valid || done) saw = 1;
         @(negedge clock);
      end
      checks++;
      if (saw || rd_cnt != rd0 || done_cnt != dn0)
         begin errors++; $display("FAIL not_halted got activity=%0b reads=%0d want none", saw, rd_cnt - rd0); end
      halted = 1'b1;
   endtask

   task automatic test_saturate();
      run_dump(5'd0, 6'd40, 0);
      checks++;
      if (got_data.size() != 32 || d_rd != 32)
         begin errors++; $display("FAIL sat_count got %0d bytes %0d reads want 32", got_data.size(), d_rd); end
   endtask

   task automatic test_abort();
      int rd0, ab0, nvalid, cyc;
      @(negedge clock);
      rd0 = rd_cnt; ab0 = abort_cnt;
      out_ready = 1'b1; base_addr = 5'h1A; length = 6'd3; start = 1'b1;
      @(negedge clock);
      start = 1'b0;
      nvalid = 0; cyc = 0;
      while (nvalid < 2 && cyc < 20) begin
         if (out_valid) nvalid++;
         if (nvalid < 2) begin @(negedge clock); cyc++; end
      end
      checks++;
      if (nvalid < 2) begin errors++; $display("FAIL abort_setup second byte never offered"); end
      halted = 1'b0;
      @(negedge clock);
      checks++;
      if (abort !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0)
         begin errors++; $display("FAIL abort_pulse got abort=%b valid=%b busy=%b want 1/0/0",
                          abort, out_valid, busy); end
      @(negedge clock);
      checks++;
      if (abort !== 1'b0) begin errors++; $display("FAIL abort_width got %b want 0", abort); end
      repeat (5) @(negedge clock);
      checks++;
      if (rd_cnt - rd0 != 2 || abort_cnt - ab0 != 1)
         begin errors++; $display("FAIL abort_reads got reads=%0d aborts=%0d want 2/1",
                          rd_cnt - rd0, abort_cnt - ab0); end
      halted = 1'b1;
   endtask

   task automatic test_reset_mid_dump();
      @(negedge clock);
      base_addr = 5'd0; length = 6'd5; start = 1'b1;
      @(negedge clock);
      start = 1'b0;
      @(negedge clock);
      reset = 1'b0;
      #1;
      checks++;
      if ({busy, out_valid, mem_rd_en, done, abort, out_last, out_data, mem_addr} !== '0)
         begin errors++; $display("FAIL midreset_outputs got busy=%b valid=%b rd=%b want all 0",
                          busy, out_valid, mem_rd_en); end
      @(negedge clock);
      reset = 1'b1;
      run_dump(5'h1B, 6'd2, 0);
      checks++;
      if (got_data.size() != 2 || first_valid != 3)
         begin errors++; $display("FAIL midreset_restart got %0d bytes first=%0d want 2/3",
                          got_data.size(), first_valid); end
      else begin
         checks++;
         if (got_data[0] !== 8'hAA || got_data[1] !== 8'hFF)
            begin errors++; $display("FAIL midreset_data got %h %h want AA FF", got_data[0], got_data[1]); end
      end
   endtask

   initial begin
      for (int i = 0; i < 32; i++) mem[i] = 8'h40 + 8'(i);
      mem[5'h1A] = 8'h01;
      mem[5'h1B] = 8'hAA;
      mem[5'h1C] = 8'hFF;
      mem[5'h1D] = 8'h00;
      mem[5'h00] = 8'hBB;
      test_reset();
      test_full_dump();
      test_wrap();
      test_backpressure();
      test_zero_and_not_halted();
      test_saturate();
      test_abort();
      test_reset_mid_dump();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
